rv_multicycle_cu: RTL and testbench

Parametrised multi-cycle control unit for the RV32I datapath. It is the successor to the bare R-type control FSM.
- Sequences FETCH/DECODE/EXECUTE/MEM/WB per instruction.
- Covers R, I-ALU, load, store, branch, JAL and LUI.
- Adds a memory ready handshake, run/idle gating and illegal-instruction trapping.
- Drives the existing datapath strobes plus the new PC-source, memory and writeback-select controls.

---
 rtl/rv_cu_pkg.sv | 51 +++++
 rtl/rv_alu_dec.sv | 28 ++
 rtl/rv_multicycle_cu.sv | 186 ++++++++++++++++++
 tb/tb_rv_multicycle_cu.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_cu_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit: states, ALU
// operation codes, major opcodes and datapath mux selects.
package rv_cu_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXE_R    = 4'd3,
    S_EXE_I    = 4'd4,
    S_WB_ALU   = 4'd5,
    S_MEM_ADDR = 4'd6,
    S_LOAD     = 4'd7,
    S_WB_LOAD  = 4'd8,
    S_STORE    = 4'd9,
    S_BRANCH   = 4'd10,
    S_JAL      = 4'd11,
    S_LUI      = 4'd12,
    S_TRAP     = 4'd13
  } state_t;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  // Register writeback source select.
  localparam logic [1:0] WD_ALU = 2'd0;
  localparam logic [1:0] WD_MEM = 2'd1;
  localparam logic [1:0] WD_PC4 = 2'd2;
  localparam logic [1:0] WD_IMM = 2'd3;

  // Next-PC source select.
  localparam logic [1:0] PCS_PC4 = 2'd0;
  localparam logic [1:0] PCS_IMM = 2'd1;

endpackage

// File: rtl/rv_alu_dec.sv
// ALU operation decoder shared by register and immediate ALU instructions.
// funct7[5] selects SUB only for register ops; SRA/SRAI honour it for both.
module rv_alu_dec
  import rv_cu_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7_b5,
  input  logic       is_imm,
  output logic [3:0] alu_op
);

  // Map funct3 (plus funct7[5] where meaningful) onto an ALU operation code.
  always_comb begin
    alu_op = ALU_ADD;
    case (funct3)
      3'b000:  alu_op = (funct7_b5 && !is_imm) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op = ALU_SLL;
      3'b010:  alu_op = ALU_SLT;
      3'b011:  alu_op = ALU_SLTU;
      3'b100:  alu_op = ALU_XOR;
      3'b101:  alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/rv_multicycle_cu.sv
// Multi-cycle control unit for the RV32I datapath. Sequences each
// instruction through FETCH/DECODE/EXECUTE/MEM/WB, waits on memory,
// gates issue with run and parks in TRAP on an illegal instruction.
module rv_multicycle_cu
  import rv_cu_pkg::*;
#(
  parameter int ALU_OP_W = 4,
  parameter int MEM_EN   = 1,
  parameter int BR_EN    = 1,
  parameter int WAIT_MEM = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                zf,
  input  logic                mem_ready,
  output logic [ALU_OP_W-1:0] ALU_OP,
  output logic                rs2_imm_s,
  output logic [1:0]          w_data_s,
  output logic [1:0]          PC_s,
  output logic                Reg_Write,
  output logic                IR_Write,
  output logic                PC_Write,
  output logic                Mem_Read,
  output logic                Mem_Write,
  output logic                illegal,
  output logic [3:0]          state_o
);

  state_t     st;
  state_t     next_st;
  state_t     end_st;
  logic       mem_rdy;
  logic       is_imm;
  logic [3:0] dec_op;
  logic       unused_funct7;

  // Only funct7[5] matters to this instruction subset.
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  // With WAIT_MEM=0 the memory is assumed to complete every access at once.
  assign mem_rdy = (WAIT_MEM != 0) ? mem_ready : 1'b1;

  // IR is stable from DECODE onward, so the opcode tells WB_ALU which
  // flavour of ALU instruction it is completing.
  assign is_imm  = (opcode == OP_I);

  // Finishing an instruction goes straight to the next fetch unless run dropped.
  assign end_st  = run ? S_FETCH : S_IDLE;

  assign state_o = st;
  assign illegal = (st == S_TRAP);

  rv_alu_dec u_alu_dec (
    .funct3    (funct3),
    .funct7_b5 (funct7[5]),
    .is_imm    (is_imm),
    .alu_op    (dec_op)
  );

  // State register; reset drops any in-flight instruction back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= S_IDLE;
    else        st <= next_st;
  end

  // Next-state selection and datapath strobes decoded from the current state.
  always_comb begin
    next_st   = st;
    ALU_OP    = '0;
    rs2_imm_s = 1'b0;
    w_data_s  = WD_ALU;
    PC_s      = PCS_PC4;
    Reg_Write = 1'b0;
    IR_Write  = 1'b0;
    PC_Write  = 1'b0;
    Mem_Read  = 1'b0;
    Mem_Write = 1'b0;
    case (st)
      S_IDLE: begin
        if (run) next_st = S_FETCH;
      end
      S_FETCH: begin
        Mem_Read = 1'b1;
        if (mem_rdy) begin
          IR_Write = 1'b1;
          PC_Write = 1'b1;
          PC_s     = PCS_PC4;
          next_st  = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_R:              next_st = S_EXE_R;
          OP_I:              next_st = S_EXE_I;
          OP_LOAD, OP_STORE: next_st = (MEM_EN != 0) ? S_MEM_ADDR : S_TRAP;
          OP_BRANCH:         next_st = (BR_EN != 0) ? S_BRANCH : S_TRAP;
          OP_JAL:            next_st = (BR_EN != 0) ? S_JAL : S_TRAP;
          OP_LUI:            next_st = S_LUI;
          default:           next_st = S_TRAP;
        endcase
      end
      S_EXE_R: begin
        ALU_OP  = ALU_OP_W'(dec_op);
        next_st = S_WB_ALU;
      end
      S_EXE_I: begin
        ALU_OP    = ALU_OP_W'(dec_op);
        rs2_imm_s = 1'b1;
        next_st   = S_WB_ALU;
      end
      S_WB_ALU: begin
        ALU_OP    = ALU_OP_W'(dec_op);
        rs2_imm_s = is_imm;
        Reg_Write = 1'b1;
        w_data_s  = WD_ALU;
        next_st   = end_st;
      end
      S_MEM_ADDR: begin
        ALU_OP    = ALU_OP_W'(ALU_ADD);
        rs2_imm_s = 1'b1;
        next_st   = opcode[5] ? S_STORE : S_LOAD;
      end
      S_LOAD: begin
        Mem_Read  = 1'b1;
        ALU_OP    = ALU_OP_W'(ALU_ADD);
        rs2_imm_s = 1'b1;
        if (mem_rdy) next_st = S_WB_LOAD;
      end
      S_WB_LOAD: begin
        Reg_Write = 1'b1;
        w_data_s  = WD_MEM;
        next_st   = end_st;
      end
      S_STORE: begin
        Mem_Write = 1'b1;
        ALU_OP    = ALU_OP_W'(ALU_ADD);
        rs2_imm_s = 1'b1;
        if (mem_rdy) next_st = end_st;
      end
      S_BRANCH: begin
        case (funct3)
          3'b000, 3'b001: begin
            ALU_OP = ALU_OP_W'(ALU_SUB);
            if (funct3[0] ? !zf : zf) begin
              PC_Write = 1'b1;
              PC_s     = PCS_IMM;
            end
            next_st = end_st;
          end
          3'b100, 3'b101, 3'b110, 3'b111: begin
            ALU_OP = funct3[1] ? ALU_OP_W'(ALU_SLTU) : ALU_OP_W'(ALU_SLT);
            if (funct3[0] ? zf : !zf) begin
              PC_Write = 1'b1;
              PC_s     = PCS_IMM;
            end
            next_st = end_st;
          end
          default: next_st = S_TRAP;
        endcase
      end
      S_JAL: begin
        Reg_Write = 1'b1;
        w_data_s  = WD_PC4;
        PC_Write  = 1'b1;
        PC_s      = PCS_IMM;
        next_st   = end_st;
      end
      S_LUI: begin
        Reg_Write = 1'b1;
        w_data_s  = WD_IMM;
        next_st   = end_st;
      end
      S_TRAP: begin
        next_st = S_TRAP;
      end
      default: begin
        next_st = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rv_multicycle_cu.sv
// Scoreboard bench for rv_multicycle_cu: per-cycle stimulus and expected
// output vectors are queued, then replayed and compared cycle by cycle.
module tb_rv_multicycle_cu;

  logic       clk = 1'b0;
  logic       rst_n, run, zf, mem_ready;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;

  logic [3:0] alu_op, alu_op_nm, st_o, st_o_nm;
  logic       imm_s, imm_s_nm, rw, rw_nm, irw, irw_nm, pcw, pcw_nm;
  logic       mr, mr_nm, mw, mw_nm, ill, ill_nm;
  logic [1:0] wds, wds_nm, pcs, pcs_nm;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rv_multicycle_cu dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .zf(zf), .mem_ready(mem_ready), .ALU_OP(alu_op),
    .rs2_imm_s(imm_s), .w_data_s(wds), .PC_s(pcs), .Reg_Write(rw),
    .IR_Write(irw), .PC_Write(pcw), .Mem_Read(mr), .Mem_Write(mw),
    .illegal(ill), .state_o(st_o)
  );

  rv_multicycle_cu #(.MEM_EN(0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .funct3(funct3),
    .funct7(funct7), .zf(zf), .mem_ready(mem_ready), .ALU_OP(alu_op_nm),
    .rs2_imm_s(imm_s_nm), .w_data_s(wds_nm), .PC_s(pcs_nm), .Reg_Write(rw_nm),
    .IR_Write(irw_nm), .PC_Write(pcw_nm), .Mem_Read(mr_nm), .Mem_Write(mw_nm),
    .illegal(ill_nm), .state_o(st_o_nm)
  );

  // {state, ALU_OP, rs2_imm_s, w_data_s, PC_s, Reg_Write, IR_Write, PC_Write, Mem_Read, Mem_Write, illegal}
  wire [18:0] obs    = {st_o, alu_op, imm_s, wds, pcs, rw, irw, pcw, mr, mw, ill};
  wire [18:0] obs_nm = {st_o_nm, alu_op_nm, imm_s_nm, wds_nm, pcs_nm, rw_nm, irw_nm, pcw_nm, mr_nm, mw_nm, ill_nm};

  typedef struct {
    logic        run;
    logic        mr;
    logic        zf;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [18:0] exp;
  } sb_t;

  sb_t   sbq[$];
  string tagq[$];

  logic [6:0]  cur_op, cur_f7;
  logic [2:0]  cur_f3;
  logic [18:0] e_idle, e_fetch, e_fwait, e_dec, e_trap;

  function automatic logic [18:0] ev(input logic [3:0] st, input logic [3:0] alu, input logic imm,
                                     input logic [1:0] wd, input logic [1:0] pc, input logic r_w,
                                     input logic ir_w, input logic pc_w, input logic m_r,
                                     input logic m_w, input logic il);
    return {st, alu, imm, wd, pc, r_w, ir_w, pc_w, m_r, m_w, il};
  endfunction

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    cur_op = op; cur_f3 = f3; cur_f7 = f7;
  endtask

  task automatic push(input logic r, input logic m, input logic z, input logic [18:0] e, input string tag);
    sb_t s;
    s.run = r; s.mr = m; s.zf = z; s.op = cur_op; s.f3 = cur_f3; s.f7 = cur_f7; s.exp = e;
    sbq.push_back(s);
    tagq.push_back(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; run = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if (obs !== e_idle) begin n_fail++; $display("[TB] FAIL reset_outputs: got %h expected %h", obs, e_idle); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== e_idle) begin n_fail++; $display("[TB] FAIL idle_hold_run0: got %h expected %h", obs, e_idle); end
    @(posedge clk); #1;
  endtask

  task automatic test_r_add();
    sb_t s; string t;
    set_instr(7'b0110011, 3'b000, 7'b0000000);
    push(1, 1, 0, e_idle, "idle_go");
    push(1, 1, 0, e_fetch, "add_fetch");
    push(1, 1, 0, e_dec, "add_decode");
    push(1, 1, 0, ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "add_exe");
    push(1, 1, 0, ev(5, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0), "add_wb");
    while (sbq.size() > 0) begin
      s = sbq.pop_front(); t = tagq.pop_front();
      run = s.run; mem_ready = s.mr; zf = s.zf; opcode = s.op; funct3 = s.f3; funct7 = s.f7;
      @(negedge clk);
      n_cmp++;
      if (obs !== s.exp) begin n_fail++; $display("[TB] FAIL %s: got %h expected %h", t, obs, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_decode();
    sb_t s; string t;
    set_instr(7'b0110011, 3'b000, 7'b0100000);
    push(1, 1, 0, e_fetch, "sub_fetch"); push(1, 1, 0, e_dec, "sub_decode");
    push(1, 1, 0, ev(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sub_exe");
    push(1, 1, 0, ev(5, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0), "sub_wb");
    set_instr(7'b0110011, 3'b111, 7'b0000000);
    push(1, 1, 0, e_fetch, "and_fetch"); push(1, 1, 0, e_dec, "and_decode");
    push(1, 1, 0, ev(3, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0), "and_exe");
    push(1, 1, 0, ev(5, 9, 0, 0, 0, 1, 0, 0, 0, 0, 0), "and_wb");
    set_instr(7'b0010011, 3'b101, 7'b0100000);
    push(1, 1, 0, e_fetch, "srai_fetch"); push(1, 1, 0, e_dec, "srai_decode");
    push(1, 1, 0, ev(4, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0), "srai_exe");
    push(1, 1, 0, ev(5, 7, 1, 0, 0, 1, 0, 0, 0, 0, 0), "srai_wb");
    set_instr(7'b0010011, 3'b000, 7'b0100000);
    push(1, 1, 0, e_fetch, "addi_fetch"); push(1, 1, 0, e_dec, "addi_decode");
    push(1, 1, 0, ev(4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "addi_exe");
    push(1, 1, 0, ev(5, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0), "addi_wb");
    set_instr(7'b0010011, 3'b011, 7'b0000000);
    push(1, 1, 0, e_fetch, "sltiu_fetch"); push(1, 1, 0, e_dec, "sltiu_decode");
    push(1, 1, 0, ev(4, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0), "sltiu_exe");
    push(1, 1, 0, ev(5, 4, 1, 0, 0, 1, 0, 0, 0, 0, 0), "sltiu_wb");
    while (sbq.size() > 0) begin
      s = sbq.pop_front(); t = tagq.pop_front();
      run = s.run; mem_ready = s.mr; zf = s.zf; opcode = s.op; funct3 = s.f3; funct7 = s.f7;
      @(negedge clk);
      n_cmp++;
      if (obs !== s.exp) begin n_fail++; $display("[TB] FAIL %s: got %h expected %h", t, obs, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_wait();
    sb_t s; string t;
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    push(1, 0, 0, e_fwait, "lw_fetch_wait");
    push(1, 1, 0, e_fetch, "lw_fetch");
    push(1, 1, 0, e_dec, "lw_decode");
    push(1, 1, 0, ev(6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "lw_mem_addr");
    for (int i = 0; i < 3; i++) push(1, 0, 0, ev(7, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0), "lw_load_wait");
    push(1, 1, 0, ev(7, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0), "lw_load_done");
    push(1, 1, 0, ev(8, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), "lw_wb");
    push(1, 1, 0, e_fetch, "lw_next_fetch");
    push(1, 1, 0, e_dec, "lw_next_decode");
    push(1, 1, 0, ev(6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "lw2_mem_addr");
    push(1, 1, 0, ev(7, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0), "lw2_load");
    push(1, 1, 0, ev(8, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0), "lw2_wb");
    while (sbq.size() > 0) begin
      s = sbq.pop_front(); t = tagq.pop_front();
      run = s.run; mem_ready = s.mr; zf = s.zf; opcode = s.op; funct3 = s.f3; funct7 = s.f7;
      @(negedge clk);
      n_cmp++;
      if (obs !== s.exp) begin n_fail++; $display("[TB] FAIL %s: got %h expected %h", t, obs, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store();
    sb_t s; string t;
    set_instr(7'b0100011, 3'b010, 7'b0000000);
    push(1, 1, 0, e_fetch, "sw_fetch");
    push(1, 1, 0, e_dec, "sw_decode");
    push(1, 1, 0, ev(6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "sw_mem_addr");
    push(1, 0, 0, ev(9, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0), "sw_store_wait");
    push(1, 1, 0, ev(9, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0), "sw_store_done");
    while (sbq.size() > 0) begin
      s = sbq.pop_front(); t = tagq.pop_front();
      run = s.run; mem_ready = s.mr; zf = s.zf; opcode = s.op; funct3 = s.f3; funct7 = s.f7;
      @(negedge clk);
      n_cmp++;
      if (obs !== s.exp) begin n_fail++; $display("[TB] FAIL %s: got %h expected %h", t, obs, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    sb_t s; string t;
    set_instr(7'b1100011, 3'b000, 7'b0000000);
    push(1, 1, 1, e_fetch, "beq_t_fetch"); push(1, 1, 1, e_dec, "beq_t_decode");
    push(1, 1, 1, ev(10, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0), "beq_taken");
    push(1, 1, 0, e_fetch, "beq_n_fetch"); push(1, 1, 0, e_dec, "beq_n_decode");
    push(1, 1, 0, ev(10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "beq_not_taken");
    set_instr(7'b1100011, 3'b110, 7'b0000000);
    push(1, 1, 0, e_fetch, "bltu_fetch"); push(1, 1, 0, e_dec, "bltu_decode");
    push(1, 1, 0, ev(10, 4, 0, 0, 1, 0, 0, 1, 0, 0, 0), "bltu_taken");
    set_instr(7'b1100011, 3'b101, 7'b0000000);
    push(1, 1, 1, e_fetch, "bge_fetch"); push(1, 1, 1, e_dec, "bge_decode");
    push(1, 1, 1, ev(10, 3, 0, 0, 1, 0, 0, 1, 0, 0, 0), "bge_taken");
    set_instr(7'b1100011, 3'b001, 7'b0000000);
    push(1, 1, 1, e_fetch, "bne_fetch"); push(1, 1, 1, e_dec, "bne_decode");
    push(1, 1, 1, ev(10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "bne_not_taken");
    set_instr(7'b1100011, 3'b100, 7'b0000000);
    push(1, 1, 1, e_fetch, "blt_fetch"); push(1, 1, 1, e_dec, "blt_decode");
    push(1, 1, 1, ev(10, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0), "blt_not_taken");
    set_instr(7'b1100011, 3'b010, 7'b0000000);
    push(1, 1, 0, e_fetch, "br010_fetch"); push(1, 1, 0, e_dec, "br010_decode");
    push(1, 1, 0, ev(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "br010_branch");
    push(1, 1, 0, e_trap, "br010_trap");
    while (sbq.size() > 0) begin
      s = sbq.pop_front(); t = tagq.pop_front();
      run = s.run; mem_ready = s.mr; zf = s.zf; opcode = s.op; funct3 = s.f3; funct7 = s.f7;
      @(negedge clk);
      n_cmp++;
      if (obs !== s.exp) begin n_fail++; $display("[TB] FAIL %s: got %h expected %h", t, obs, s.exp); end
      @(posedge clk); #1;
    end
    do_reset();
  endtask

  task automatic test_jal_lui();
    sb_t s; string t;
    set_instr(7'b1101111, 3'b000, 7'b0000000);
    push(1, 1, 0, e_idle, "jal_idle_go");
    push(1, 1, 0, e_fetch, "jal_fetch"); push(1, 1, 0, e_dec, "jal_decode");
    push(1, 1, 0, ev(11, 0, 0, 2, 1, 1, 0, 1, 0, 0, 0), "jal_exec");
    set_instr(7'b0110111, 3'b000, 7'b0000000);
    push(1, 1, 0, e_fetch, "lui_fetch"); push(1, 1, 0, e_dec, "lui_decode");
    push(0, 1, 0, ev(12, 0, 0, 3, 0, 1, 0, 0, 0, 0, 0), "lui_exec_stop");
    push(0, 1, 0, e_idle, "stopped_idle");
    push(1, 1, 0, e_idle, "restart_idle_go");
    while (sbq.size() > 0) begin
      s = sbq.pop_front(); t = tagq.pop_front();
      run = s.run; mem_ready = s.mr; zf = s.zf; opcode = s.op; funct3 = s.f3; funct7 = s.f7;
      @(negedge clk);
      n_cmp++;
      if (obs !== s.exp) begin n_fail++; $display("[TB] FAIL %s: got %h expected %h", t, obs, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_trap();
    sb_t s; string t;
    set_instr(7'b1111111, 3'b000, 7'b0000000);
    push(1, 1, 0, e_fetch, "bad_fetch"); push(1, 1, 0, e_dec, "bad_decode");
    for (int i = 0; i < 10; i++) push(logic'(i % 2), 1, 0, e_trap, "trap_hold");
    while (sbq.size() > 0) begin
      s = sbq.pop_front(); t = tagq.pop_front();
      run = s.run; mem_ready = s.mr; zf = s.zf; opcode = s.op; funct3 = s.f3; funct7 = s.f7;
      @(negedge clk);
      n_cmp++;
      if (obs !== s.exp) begin n_fail++; $display("[TB] FAIL %s: got %h expected %h", t, obs, s.exp); end
      @(posedge clk); #1;
    end
    run = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== e_idle) begin n_fail++; $display("[TB] FAIL trap_reset: got %h expected %h", obs, e_idle); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs !== e_idle) begin n_fail++; $display("[TB] FAIL idle_after_trap: got %h expected %h", obs, e_idle); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    sb_t s; string t;
    set_instr(7'b0100011, 3'b000, 7'b0000000);
    push(1, 1, 0, e_idle, "sr_idle_go");
    push(1, 1, 0, e_fetch, "sr_fetch"); push(1, 1, 0, e_dec, "sr_decode");
    push(1, 1, 0, ev(6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0), "sr_mem_addr");
    push(1, 0, 0, ev(9, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0), "sr_store_wait");
    while (sbq.size() > 0) begin
      s = sbq.pop_front(); t = tagq.pop_front();
      run = s.run; mem_ready = s.mr; zf = s.zf; opcode = s.op; funct3 = s.f3; funct7 = s.f7;
      @(negedge clk);
      n_cmp++;
      if (obs !== s.exp) begin n_fail++; $display("[TB] FAIL %s: got %h expected %h", t, obs, s.exp); end
      @(posedge clk); #1;
    end
    #2;
    n_cmp++;
    if (mw !== 1'b1) begin n_fail++; $display("[TB] FAIL store_still_waiting: got Mem_Write=%b expected 1", mw); end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== e_idle) begin n_fail++; $display("[TB] FAIL store_async_reset: got %h expected %h", obs, e_idle); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
  endtask

  task automatic test_mem_en0();
    sb_t s; string t;
    do_reset();
    set_instr(7'b0000011, 3'b010, 7'b0000000);
    push(1, 1, 0, e_idle, "nm_idle_go");
    push(1, 1, 0, e_fetch, "nm_fetch");
    push(1, 1, 0, e_dec, "nm_decode");
    push(1, 1, 0, e_trap, "nm_load_trap");
    push(0, 1, 0, e_trap, "nm_trap_hold");
    while (sbq.size() > 0) begin
      s = sbq.pop_front(); t = tagq.pop_front();
      run = s.run; mem_ready = s.mr; zf = s.zf; opcode = s.op; funct3 = s.f3; funct7 = s.f7;
      @(negedge clk);
      n_cmp++;
      if (obs_nm !== s.exp) begin n_fail++; $display("[TB] FAIL %s: got %h expected %h", t, obs_nm, s.exp); end
      @(posedge clk); #1;
    end
  endtask

  // Bound the whole run in case the sequencing above ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    e_idle  = '0;
    e_fetch = ev(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    e_fwait = ev(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    e_dec   = ev(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    e_trap  = ev(13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst_n = 1'b0; run = 1'b0; zf = 1'b0; mem_ready = 1'b1;
    opcode = '0; funct3 = '0; funct7 = '0;
    set_instr(7'b0, 3'b0, 7'b0);
    test_reset();
    test_r_add();
    test_alu_decode();
    test_load_wait();
    test_store();
    test_branch();
    test_jal_lui();
    test_trap();
    test_async_reset();
    test_mem_en0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
